// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Shared display constants, RGB444 type, box palette and animator FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef logic [11:0] rgb444_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } anim_state_t;

    localparam rgb444_t PALETTE [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'hF80
    };

endpackage

`default_nettype wire

// File: rtl/box_axis_ctrl.sv
// ============================================================================
// Module : box_axis_ctrl
// One axis of the bouncing box: position, direction (1 = decreasing), bounce.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module box_axis_ctrl #(
    parameter int LIMIT = 640,
    parameter int SIZE  = 32,
    parameter int STEP  = 2,
    parameter int START = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step_en,
    output logic [9:0] pos,
    output logic       dir,
    output logic       bounce
);

    localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    logic [10:0] pos_ext;
    logic [10:0] pos_next;
    logic        dir_next;

    assign pos_ext = {1'b0, pos};

    // 11-bit math keeps pos+STEP from wrapping near the right/bottom edge
    always_comb begin
        pos_next = pos_ext;
        dir_next = dir;
        bounce   = 1'b0;
        if (step_en) begin
            if (!dir) begin
                if (pos_ext + STEP_W >= MAX_POS) begin
                    pos_next = MAX_POS;
                    dir_next = 1'b1;
                    bounce   = 1'b1;
                end else begin
                    pos_next = pos_ext + STEP_W;
                end
            end else begin
                if (pos_ext <= STEP_W) begin
                    pos_next = '0;
                    dir_next = 1'b0;
                    bounce   = 1'b1;
                end else begin
                    pos_next = pos_ext - STEP_W;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= 10'(START);
            dir <= 1'b0;
        end else begin
            pos <= pos_next[9:0];
            dir <= dir_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_box_animator.sv
// ============================================================================
// Module : vga_box_animator
// Bouncing-box pixel source; define COLOR_CYCLE_EN to step the palette per bounce.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_box_animator
    import vga_pkg::*;
#(
    parameter int      H_ACTIVE  = H_ACTIVE_DEFAULT,
    parameter int      V_ACTIVE  = V_ACTIVE_DEFAULT,
    parameter int      BOX_W     = 32,
    parameter int      BOX_H     = 32,
    parameter int      STEP      = 2,
    parameter int      X0        = 0,
    parameter int      Y0        = 0,
    parameter rgb444_t BG_COLOR  = 12'h000,
    parameter rgb444_t BOX_COLOR = 12'hF00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output rgb444_t    pixel,
    output logic       frame_tick,
    output logic       bounce
);

    anim_state_t state;
    anim_state_t state_next;
    logic        vs_d;
    logic        tick;
    logic        step_en;
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic        bounce_x;
    logic        bounce_y;
    logic        dir_x_unused;
    logic        dir_y_unused;
    rgb444_t     box_color;
    rgb444_t     pixel_next;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] bx_ext;
    logic [10:0] by_ext;

    assign tick    = vs_d & ~vs;
    assign step_en = tick && (state == RUN);

    box_axis_ctrl #(
        .LIMIT (H_ACTIVE),
        .SIZE  (BOX_W),
        .STEP  (STEP),
        .START (X0)
    ) u_axis_x (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .pos     (box_x),
        .dir     (dir_x_unused),
        .bounce  (bounce_x)
    );

    box_axis_ctrl #(
        .LIMIT (V_ACTIVE),
        .SIZE  (BOX_H),
        .STEP  (STEP),
        .START (Y0)
    ) u_axis_y (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .pos     (box_y),
        .dir     (dir_y_unused),
        .bounce  (bounce_y)
    );

`ifdef COLOR_CYCLE_EN
    logic [2:0] color_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            color_idx <= 3'd0;
        end else if (bounce) begin
            color_idx <= color_idx + 3'd1;
        end
    end

    assign box_color = PALETTE[color_idx];
`else
    assign box_color = BOX_COLOR;
`endif

    // The first tick after reset only aligns to the frame; movement starts next tick
    always_comb begin
        state_next = state;
        if (state == IDLE && tick) begin
            state_next = RUN;
        end
    end

    assign x_ext  = {1'b0, x};
    assign y_ext  = {1'b0, y};
    assign bx_ext = {1'b0, box_x};
    assign by_ext = {1'b0, box_y};

    always_comb begin
        pixel_next = BG_COLOR;
        if (x_ext >= 11'(H_ACTIVE) || y_ext >= 11'(V_ACTIVE)) begin
            pixel_next = '0;
        end else if (x_ext >= bx_ext && x_ext < bx_ext + 11'(BOX_W) &&
                     y_ext >= by_ext && y_ext < by_ext + 11'(BOX_H)) begin
            pixel_next = box_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
            bounce     <= 1'b0;
            pixel      <= '0;
        end else begin
            state      <= state_next;
            vs_d       <= vs;
            frame_tick <= tick;
            bounce     <= bounce_x | bounce_y;
            pixel      <= pixel_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_box_animator.sv
// ============================================================================
// Module : tb_vga_box_animator
// Randomized bench for vga_box_animator against a frame-level box model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_box_animator;

    localparam int          H  = 640;
    localparam int          V  = 480;
    localparam int          BW = 32;
    localparam int          BH = 32;
    localparam int          ST = 2;
    localparam logic [11:0] BG = 12'h000;
    localparam logic [11:0] BC = 12'hF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic        vs2;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] pixel;
    logic [11:0] pixel2;
    logic        frame_tick;
    logic        frame_tick2;
    logic        bounce;
    logic        bounce2;

    int vectors;
    int miscompares;

    // frame-level model of the main instance
    int mbx, mby, mdx, mdy, midx;
    bit mrun;
    logic [11:0] pal [8];

    always #5 clk = ~clk;

    vga_box_animator #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BOX_W(BW), .BOX_H(BH), .STEP(ST),
        .X0(0), .Y0(0), .BG_COLOR(BG), .BOX_COLOR(BC)
    ) dut (
        .clk(clk), .rst(rst), .vs(vs), .x(x), .y(y),
        .pixel(pixel), .frame_tick(frame_tick), .bounce(bounce)
    );

    vga_box_animator #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BOX_W(BW), .BOX_H(BH), .STEP(ST),
        .X0(608), .Y0(448), .BG_COLOR(BG), .BOX_COLOR(BC)
    ) dut_corner (
        .clk(clk), .rst(rst), .vs(vs2), .x(x), .y(y),
        .pixel(pixel2), .frame_tick(frame_tick2), .bounce(bounce2)
    );

    function automatic logic [11:0] box_col(input int idx);
`ifdef COLOR_CYCLE_EN
        return pal[idx % 8];
`else
        return BC;
`endif
    endfunction

    function automatic logic [11:0] model_px(input int px, input int py);
        if (px >= H || py >= V) return 12'h000;
        if (px >= mbx && px < mbx + BW && py >= mby && py < mby + BH) return box_col(midx);
        return BG;
    endfunction

    task automatic model_reset();
        mbx = 0; mby = 0; mdx = 1; mdy = 1; midx = 0; mrun = 0;
    endtask

    task automatic model_tick(output bit b);
        b = 0;
        if (!mrun) begin
            mrun = 1;
            return;
        end
        if (mdx > 0) begin
            if (mbx + ST >= H - BW) begin mbx = H - BW; mdx = -1; b = 1; end
            else mbx = mbx + ST;
        end else begin
            if (mbx <= ST) begin mbx = 0; mdx = 1; b = 1; end
            else mbx = mbx - ST;
        end
        if (mdy > 0) begin
            if (mby + ST >= V - BH) begin mby = V - BH; mdy = -1; b = 1; end
            else mby = mby + ST;
        end else begin
            if (mby <= ST) begin mby = 0; mdy = 1; b = 1; end
            else mby = mby - ST;
        end
        if (b) midx = (midx + 1) % 8;
    endtask

    task automatic probe(input int px, input int py, output logic [11:0] got, output logic [11:0] got2);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        @(negedge clk);
        got  = pixel;
        got2 = pixel2;
    endtask

    // one vs low pulse of 'low' cycles on the main instance, checking tick/bounce pulses
    task automatic run_frame(input int low);
        bit b;
        model_tick(b);
        @(negedge clk);
        vs = 1'b0;
        for (int i = 0; i < low; i++) begin
            @(negedge clk);
            vectors++;
            if (frame_tick !== (i == 0)) begin
                miscompares++;
                $display("FAIL frame_tick cyc=%0d got=%b exp=%b", i, frame_tick, (i == 0));
            end
            vectors++;
            if (bounce !== ((i == 0) && b)) begin
                miscompares++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b box=(%0d,%0d)", i, bounce, ((i == 0) && b), mbx, mby);
            end
        end
        vs = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vs = 1'b1; vs2 = 1'b1; x = 10'd0; y = 10'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (pixel !== 12'h000 || pixel2 !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_pixel got=%h/%h exp=000", pixel, pixel2);
        end
        vectors++;
        if (frame_tick !== 1'b0 || bounce !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses got=%b%b exp=00", frame_tick, bounce);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_first_tick();
        logic [11:0] g, g2;
        run_frame(1);
        probe(0, 0, g, g2);
        vectors++;
        if (g !== BC) begin miscompares++; $display("FAIL first_tick_00 got=%h exp=%h", g, BC); end
        probe(31, 31, g, g2);
        vectors++;
        if (g !== BC) begin miscompares++; $display("FAIL first_tick_31 got=%h exp=%h", g, BC); end
        probe(32, 0, g, g2);
        vectors++;
        if (g !== BG) begin miscompares++; $display("FAIL first_tick_32 got=%h exp=%h", g, BG); end
    endtask

    task automatic test_second_tick();
        logic [11:0] g, g2;
        run_frame(2);
        probe(2, 2, g, g2);
        vectors++;
        if (g !== 12'hF00) begin miscompares++; $display("FAIL second_tick_2_2 got=%h exp=f00", g); end
        probe(34, 2, g, g2);
        vectors++;
        if (g !== BG) begin miscompares++; $display("FAIL second_tick_34_2 got=%h exp=%h", g, BG); end
        probe(1, 2, g, g2);
        vectors++;
        if (g !== BG) begin miscompares++; $display("FAIL second_tick_1_2 got=%h exp=%h", g, BG); end
    endtask

    task automatic test_random_frames();
        logic [11:0] g, g2, e;
        int px, py;
        for (int f = 0; f < 340; f++) begin
            run_frame(int'($urandom_range(1, 3)));
            px = mbx + int'($urandom_range(0, 36)) - 2;
            py = mby + int'($urandom_range(0, 36)) - 2;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            probe(px, py, g, g2);
            e = model_px(px, py);
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL near_box f=%0d (%0d,%0d) got=%h exp=%h", f, px, py, g, e);
            end
            px = int'($urandom_range(0, 799));
            py = int'($urandom_range(0, 524));
            probe(px, py, g, g2);
            e = model_px(px, py);
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL any_pixel f=%0d (%0d,%0d) got=%h exp=%h", f, px, py, g, e);
            end
        end
    endtask

    task automatic test_blanking();
        logic [11:0] g, g2;
        probe(700, int'($urandom_range(0, 479)), g, g2);
        vectors++;
        if (g !== 12'h000) begin miscompares++; $display("FAIL blank_x700 got=%h exp=000", g); end
        probe(int'($urandom_range(0, 639)), 500, g, g2);
        vectors++;
        if (g !== 12'h000) begin miscompares++; $display("FAIL blank_y500 got=%h exp=000", g); end
        probe(640, 0, g, g2);
        vectors++;
        if (g !== 12'h000) begin miscompares++; $display("FAIL blank_x640 got=%h exp=000", g); end
    endtask

    task automatic test_vs_long();
        logic [11:0] g, g2, e;
        int cnt;
        bit b;
        model_tick(b);
        cnt = 0;
        @(negedge clk);
        vs = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (frame_tick === 1'b1) cnt++;
        end
        vs = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (frame_tick === 1'b1) cnt++;
        end
        vectors++;
        if (cnt !== 1) begin miscompares++; $display("FAIL vs_long_ticks got=%0d exp=1", cnt); end
        probe(mbx, mby, g, g2);
        e = model_px(mbx, mby);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL vs_long_pos got=%h exp=%h", g, e); end
        probe(mbx + BW, mby, g, g2);
        e = model_px(mbx + BW, mby);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL vs_long_edge got=%h exp=%h", g, e); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] g, g2;
        @(negedge clk);
        x = 10'(mbx); y = 10'(mby);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (pixel !== 12'h000) begin miscompares++; $display("FAIL rst_mid_pixel got=%h exp=000", pixel); end
        rst = 1'b0;
        model_reset();
        probe(0, 0, g, g2);
        vectors++;
        if (g !== BC) begin miscompares++; $display("FAIL rst_mid_home got=%h exp=%h", g, BC); end
        run_frame(1);
        probe(0, 0, g, g2);
        vectors++;
        if (g !== BC) begin miscompares++; $display("FAIL rst_idle_nomove got=%h exp=%h", g, BC); end
        probe(32, 32, g, g2);
        vectors++;
        if (g !== BG) begin miscompares++; $display("FAIL rst_idle_edge got=%h exp=%h", g, BG); end
    endtask

    task automatic test_corner();
        logic [11:0] g, g2, e;
        int nb, nt;
        e = box_col(1);
        for (int p = 0; p < 3; p++) begin
            nb = 0; nt = 0;
            @(negedge clk);
            vs2 = 1'b0;
            @(negedge clk);
            vs2 = 1'b1;
            if (frame_tick2 === 1'b1) nt++;
            if (bounce2 === 1'b1) nb++;
            repeat (4) begin
                @(negedge clk);
                if (frame_tick2 === 1'b1) nt++;
                if (bounce2 === 1'b1) nb++;
            end
            vectors++;
            if (nt !== 1) begin miscompares++; $display("FAIL corner_tick p=%0d got=%0d exp=1", p, nt); end
            vectors++;
            if (nb !== ((p == 1) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL corner_bounce p=%0d got=%0d exp=%0d", p, nb, (p == 1) ? 1 : 0);
            end
            if (p == 1) begin
                probe(608, 448, g, g2);
                vectors++;
                if (g2 !== e) begin miscompares++; $display("FAIL corner_pos got=%h exp=%h", g2, e); end
                probe(607, 448, g, g2);
                vectors++;
                if (g2 !== BG) begin miscompares++; $display("FAIL corner_left got=%h exp=%h", g2, BG); end
            end
        end
        probe(606, 446, g, g2);
        vectors++;
        if (g2 !== e) begin miscompares++; $display("FAIL corner_return got=%h exp=%h", g2, e); end
        probe(639, 479, g, g2);
        vectors++;
        if (g2 !== BG) begin miscompares++; $display("FAIL corner_vacated got=%h exp=%h", g2, BG); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        pal[0] = 12'hF00; pal[1] = 12'h0F0; pal[2] = 12'h00F; pal[3] = 12'hFF0;
        pal[4] = 12'h0FF; pal[5] = 12'hF0F; pal[6] = 12'hFFF; pal[7] = 12'hF80;
        model_reset();
        test_reset();
        test_first_tick();
        test_second_tick();
        test_random_frames();
        test_blanking();
        test_vs_long();
        test_reset_mid();
        test_corner();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
